// File: rtl/muldiv_controller.sv
// Multi-cycle controller for the MIPS multiply/divide unit: captures operands on issue,
// models the fixed unit latency with a countdown, and owns the HI/LO architectural registers.
module muldiv_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  logic        load_HI,
    input  logic        load_LO,
    input  logic [31:0] load_value,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [7:0] MULT_LAST = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LAST  = 8'(DIV_CYCLES - 1);

    // Full result {hi, lo} for one mult/multu/div/divu; division works on magnitudes
    // and restores signs so quotient truncates toward zero and remainder follows the dividend.
    function automatic logic [63:0] f_compute(input logic [1:0]  f_op,
                                              input logic [31:0] f_a,
                                              input logic [31:0] f_b);
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        logic        [31:0] mag_a;
        logic        [31:0] mag_b;
        logic        [31:0] quo;
        logic        [31:0] rem;
        logic               neg_a;
        logic               neg_b;
        logic        [63:0] res;
        sprod = $signed({{32{f_a[31]}}, f_a}) * $signed({{32{f_b[31]}}, f_b});
        uprod = {32'd0, f_a} * {32'd0, f_b};
        neg_a = ~f_op[0] & f_a[31];
        neg_b = ~f_op[0] & f_b[31];
        mag_a = neg_a ? (32'd0 - f_a) : f_a;
        mag_b = neg_b ? (32'd0 - f_b) : f_b;
        quo   = 32'd0;
        rem   = 32'd0;
        if (mag_b != 32'd0) begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        quo = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
        rem = neg_a ? (32'd0 - rem) : rem;
        case (f_op)
            2'b00:   res = sprod;
            2'b01:   res = uprod;
            default: res = (f_b == 32'd0) ? {f_a, 32'hFFFF_FFFF} : {rem, quo};
        endcase
        return res;
    endfunction

    logic [0:0]  r_state;
    logic [7:0]  r_count;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic [63:0] w_result;

    assign w_result = f_compute(op, rs_value, rt_value);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_count   <= 8'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_HI) r_hi <= load_value;
                    if (load_LO) r_lo <= load_value;
                    if (start) begin
                        r_pend_hi <= w_result[63:32];
                        r_pend_lo <= w_result[31:0];
                        r_count   <= op[1] ? DIV_LAST : MULT_LAST;
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    // Commit beats abort: a load on the final edge only overrides its own register.
                    if (r_count == 8'd0) begin
                        r_hi    <= load_HI ? load_value : r_pend_hi;
                        r_lo    <= load_LO ? load_value : r_pend_lo;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (load_HI || load_LO) begin
                        if (load_HI) r_hi <= load_value;
                        if (load_LO) r_lo <= load_value;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: directed and random issue sequences
// checked against an arithmetic reference model of the HI/LO architectural state.
module tb_muldiv_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        load_HI;
    logic        load_LO;
    logic [31:0] load_value;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    logic        b_start;
    logic [1:0]  b_op;
    logic [31:0] b_rs;
    logic [31:0] b_rt;
    logic        b_busy;
    logic        b_done;
    logic [31:0] b_HI;
    logic [31:0] b_LO;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    muldiv_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_value(rs_value), .rt_value(rt_value),
        .load_HI(load_HI), .load_LO(load_LO), .load_value(load_value),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    muldiv_controller #(.MULT_CYCLES(1), .DIV_CYCLES(10)) dut_fast (
        .clk(clk), .reset(reset), .start(b_start), .op(b_op),
        .rs_value(b_rs), .rt_value(b_rt),
        .load_HI(1'b0), .load_LO(1'b0), .load_value(32'd0),
        .busy(b_busy), .done(b_done), .HI(b_HI), .LO(b_LO)
    );

    // Reference: MIPS semantics written with the simulator's own signed/unsigned arithmetic.
    function automatic logic [63:0] ref_calc(input logic [1:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sp;
        int sa;
        int sb;
        logic [63:0] r;
        sa = a;
        sb = b;
        r  = 64'd0;
        case (f_op)
            2'd0: begin
                sp = longint'(sa) * longint'(sb);
                r  = sp;
            end
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0)                                   r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else                                              r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int n;
        r = ref_calc(o, a, b);
        n = o[1] ? 10 : 5;
        start = 1'b1; op = o; rs_value = a; rt_value = b;
        cyc();
        start = 1'b0;
        chkb("busy_issue", busy, 1'b1);
        chkb("done_issue", done, 1'b0);
        for (int i = 1; i < n; i++) begin
            cyc();
            chkb("busy_run", busy, 1'b1);
            chkb("done_run", done, 1'b0);
            chk("hi_hold", HI, m_hi);
        end
        cyc();
        chkb("busy_commit", busy, 1'b0);
        chkb("done_commit", done, 1'b1);
        chk("hi_result", HI, r[63:32]);
        chk("lo_result", LO, r[31:0]);
        m_hi = r[63:32];
        m_lo = r[31:0];
        cyc();
        chkb("done_pulse_end", done, 1'b0);
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        logic        b_idle;
        logic [63:0] b_pend;
        logic [31:0] b_mhi;
        logic [31:0] b_mlo;

        reset = 1'b0; start = 1'b0; op = 2'd0; rs_value = 32'd0; rt_value = 32'd0;
        load_HI = 1'b0; load_LO = 1'b0; load_value = 32'd0;
        b_start = 1'b0; b_op = 2'd0; b_rs = 32'd0; b_rt = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        #1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // Directed arithmetic corners.
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_lit", HI, 32'hFFFF_FFFF);
        chk("mult_lo_lit", LO, 32'hFFFF_FFFA);
        run_op(2'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi_lit", HI, 32'h0000_0002);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_lit", LO, 32'hFFFF_FFFD);
        run_op(2'd3, 32'd7, 32'd0);
        chk("divu0_hi_lit", HI, 32'd7);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_lit", LO, 32'h8000_0000);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0);
        run_op(2'd2, 32'd100, 32'hFFFF_FFF9);

        // Randomized operations.
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 17));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: b = $urandom;
            endcase
            run_op(o, a, b);
        end

        // Start while busy is ignored.
        r = ref_calc(2'd0, 32'd100, 32'd200);
        start = 1'b1; op = 2'd0; rs_value = 32'd100; rt_value = 32'd200;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1; op = 2'd2; rs_value = 32'd9; rt_value = 32'd3;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chkb("ign_busy", busy, 1'b1);
        chkb("ign_done_early", done, 1'b0);
        cyc();
        chkb("ign_done", done, 1'b1);
        chk("ign_hi", HI, r[63:32]);
        chk("ign_lo", LO, r[31:0]);
        m_hi = r[63:32]; m_lo = r[31:0];
        for (int i = 0; i < 12; i++) begin
            cyc();
            chkb("ign_no_done", done, 1'b0);
            chkb("ign_no_busy", busy, 1'b0);
        end

        // load_LO aborts a mult at busy cycle 3.
        start = 1'b1; op = 2'd0; rs_value = 32'd7; rt_value = 32'd9;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        load_LO = 1'b1; load_value = 32'h0000_1234;
        cyc();
        load_LO = 1'b0;
        chkb("abort_busy", busy, 1'b0);
        chkb("abort_done", done, 1'b0);
        chk("abort_lo", LO, 32'h0000_1234);
        chk("abort_hi", HI, m_hi);
        m_lo = 32'h0000_1234;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chkb("abort_no_done", done, 1'b0);
            chk("abort_hi_keep", HI, m_hi);
            chk("abort_lo_keep", LO, m_lo);
        end

        // Idle loads.
        load_HI = 1'b1; load_LO = 1'b1; load_value = 32'hCAFE_F00D;
        cyc();
        load_HI = 1'b0; load_LO = 1'b0;
        chk("ld_both_hi", HI, 32'hCAFE_F00D);
        chk("ld_both_lo", LO, 32'hCAFE_F00D);
        m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
        load_HI = 1'b1; load_value = 32'h1111_1111;
        cyc();
        load_HI = 1'b0;
        chk("ld_hi_only", HI, 32'h1111_1111);
        chk("ld_hi_lo_keep", LO, m_lo);
        m_hi = 32'h1111_1111;

        // Load and start in the same idle cycle.
        load_HI = 1'b1; load_value = 32'hAAAA_5555;
        start = 1'b1; op = 2'd1; rs_value = 32'd6; rt_value = 32'd7;
        cyc();
        load_HI = 1'b0; start = 1'b0;
        chk("ldst_hi", HI, 32'hAAAA_5555);
        chk("ldst_lo", LO, m_lo);
        chkb("ldst_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) cyc();
        chkb("ldst_busy_last", busy, 1'b1);
        cyc();
        chkb("ldst_done", done, 1'b1);
        chk("ldst_res_hi", HI, 32'd0);
        chk("ldst_res_lo", LO, 32'd42);
        m_hi = 32'd0; m_lo = 32'd42;

        // Load coincident with the commit edge.
        r = ref_calc(2'd0, 32'hFFFF_FFFD, 32'd4);
        start = 1'b1; op = 2'd0; rs_value = 32'hFFFF_FFFD; rt_value = 32'd4;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        load_HI = 1'b1; load_value = 32'h5A5A_5A5A;
        cyc();
        load_HI = 1'b0;
        chkb("ldc_done", done, 1'b1);
        chkb("ldc_busy", busy, 1'b0);
        chk("ldc_hi", HI, 32'h5A5A_5A5A);
        chk("ldc_lo", LO, r[31:0]);
        m_hi = 32'h5A5A_5A5A; m_lo = r[31:0];

        // Asynchronous reset with an operation in flight.
        start = 1'b1; op = 2'd2; rs_value = 32'd1000; rt_value = 32'd7;
        cyc();
        start = 1'b0;
        cyc();
        chkb("rstm_busy_before", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chkb("rstm_busy", busy, 1'b0);
        chkb("rstm_done", done, 1'b0);
        chk("rstm_hi", HI, 32'd0);
        chk("rstm_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chkb("rstm_no_busy", busy, 1'b0);
            chkb("rstm_no_done", done, 1'b0);
        end
        chk("rstm_hi_after", HI, 32'd0);

        // Single-cycle multiply with start held every cycle.
        b_idle = 1'b1; b_pend = 64'd0; b_mhi = 32'd0; b_mlo = 32'd0;
        for (int i = 0; i < 8; i++) begin
            b_start = 1'b1;
            b_op = 2'($urandom_range(0, 1));
            b_rs = $urandom;
            b_rt = $urandom;
            if (b_idle) b_pend = ref_calc(b_op, b_rs, b_rt);
            cyc();
            if (b_idle) begin
                chkb("fast_acc_busy", b_busy, 1'b1);
                chkb("fast_acc_done", b_done, 1'b0);
                chk("fast_acc_hi", b_HI, b_mhi);
                b_idle = 1'b0;
            end else begin
                b_mhi = b_pend[63:32];
                b_mlo = b_pend[31:0];
                chkb("fast_cm_busy", b_busy, 1'b0);
                chkb("fast_cm_done", b_done, 1'b1);
                chk("fast_cm_hi", b_HI, b_mhi);
                chk("fast_cm_lo", b_LO, b_mlo);
                b_idle = 1'b1;
            end
        end
        b_start = 1'b0;
        cyc();
        chkb("fast_end_busy", b_busy, 1'b0);
        chkb("fast_end_done", b_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
